// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue over a req/ack memory port.
// Define IF_PERF_CNT_EN to add fetch/flush/stall performance counters.
module if_fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        PC_STEP  = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] PC,
  output logic [INST_W-1:0] Instruction
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic              issue, push, pop;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & ~freeze & ~Branch_taken;
  // Issue uses the registered count, so a same-cycle pop never frees a slot for it.
  assign issue      = (state_q == StIdle) & ~Branch_taken & (count_q < CntW'(DEPTH));
  assign imem_req   = issue & rst;
  assign imem_addr  = fetch_pc_q;

  assign PC          = inst_valid ? (pc_mem[head_q] + ADDR_W'(PC_STEP)) : '0;
  assign Instruction = inst_valid ? inst_mem[head_q] : '0;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + ADDR_W'(PC_STEP);
          state_d     = StWait;
        end
      end
      StWait: begin
        if (imem_ack) begin
          push    = ~Branch_taken;
          state_d = StIdle;
        end else if (Branch_taken) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (Branch_taken) begin
      fetch_pc_d = BranchAddr;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (Branch_taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      if (push) begin
        tail_d = tail_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= issued_pc_q;
      inst_mem[tail_q] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (Branch_taken) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if (!inst_valid && !Branch_taken) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
